// File: rtl/sim_fixed_pkg.sv
// Shared fixed-point types, limits and saturating arithmetic helpers for the
// circuit-simulator datapath (signed Q8.8 at default widths).
package sim_fixed_pkg;

    localparam int W    = 16;
    localparam int FRAC = 8;

    localparam logic signed [W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [W-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_L = 3'd1,
        MUL_C = 3'd2,
        UPD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Clamp a W+1 bit intermediate back into the W-bit range; overflow shows as differing top bits.
    function automatic logic signed [W-1:0] sat_wide(input logic signed [W:0] s);
        logic signed [W-1:0] r;
        if (s[W] != s[W-1]) begin
            r = s[W] ? Q_MIN : Q_MAX;
        end else begin
            r = s[W-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        return sat_wide({a[W-1], a} + {b[W-1], b});
    endfunction

    function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        return sat_wide({a[W-1], a} - {b[W-1], b});
    endfunction

    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] a);
        return sat_sub({W{1'b0}}, a);
    endfunction

endpackage

// File: rtl/sat_fixed_mul.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic
// shift (truncation toward -inf), then saturation to the W-bit range.
module sat_fixed_mul
    import sim_fixed_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p
);

    logic signed [2*W-1:0] a_ext_s;
    logic signed [2*W-1:0] b_ext_s;
    logic signed [2*W-1:0] prod_s;
    logic signed [2*W-1:0] shift_s;
    logic                  fits_s;

    assign a_ext_s = {{W{a[W-1]}}, a};
    assign b_ext_s = {{W{b[W-1]}}, b};
    assign prod_s  = a_ext_s * b_ext_s;
    assign shift_s = prod_s >>> FRAC;
    // Result fits when every bit from the W-bit sign position upward agrees.
    assign fits_s  = (&shift_s[2*W-1:W-1]) | (~|shift_s[2*W-1:W-1]);

    // Select truncated product or the saturation limit matching the product sign.
    always_comb begin
        p = shift_s[W-1:0];
        if (fits_s) begin
            p = shift_s[W-1:0];
        end else if (shift_s[2*W-1]) begin
            p = Q_MIN;
        end else begin
            p = Q_MAX;
        end
    end

endmodule

// File: rtl/companion_history_update.sv
// Trapezoidal companion-model history update: one shared saturating multiplier
// sequenced over MUL_L/MUL_C/UPD/DONE, producing z = [-I_L ; I_L+I_C ; E].
module companion_history_update
    import sim_fixed_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         hist_clr,
    input  logic [W-1:0] v1,
    input  logic [W-1:0] v2,
    input  logic [W-1:0] g_l,
    input  logic [W-1:0] g_c,
    input  logic [W-1:0] e_src,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] z0,
    output logic [W-1:0] z1,
    output logic [W-1:0] z2
);

    state_t state_r;
    state_t state_next_s;

    logic signed [W-1:0] v1_r, v2_r, g_l_r, g_c_r, e_r;
    logic signed [W-1:0] i_l_r, i_c_r;
    logic signed [W-1:0] p_l_r, p_c_r;
    logic signed [W-1:0] diff_s, mul_a_s, mul_b_s, mul_p_s;

    assign diff_s = sat_sub(v1_r, v2_r);

    sat_fixed_mul u_mul (
        .a (mul_a_s),
        .b (mul_b_s),
        .p (mul_p_s)
    );

    // Operand mux for the shared multiplier: inductor branch except in MUL_C.
    always_comb begin
        mul_a_s = diff_s;
        mul_b_s = g_l_r;
        if (state_r == MUL_C) begin
            mul_a_s = v2_r;
            mul_b_s = g_c_r;
        end else begin
            mul_a_s = diff_s;
            mul_b_s = g_l_r;
        end
    end

    // Next-state logic; clear outranks start in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = (start && !hist_clr) ? MUL_L : IDLE;
            MUL_L:   state_next_s = MUL_C;
            MUL_C:   state_next_s = UPD;
            UPD:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            z0    <= {W{1'b0}};
            z1    <= {W{1'b0}};
            z2    <= {W{1'b0}};
            i_l_r <= {W{1'b0}};
            i_c_r <= {W{1'b0}};
            p_l_r <= {W{1'b0}};
            p_c_r <= {W{1'b0}};
            v1_r  <= {W{1'b0}};
            v2_r  <= {W{1'b0}};
            g_l_r <= {W{1'b0}};
            g_c_r <= {W{1'b0}};
            e_r   <= {W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (hist_clr) begin
                        i_l_r <= {W{1'b0}};
                        i_c_r <= {W{1'b0}};
                    end else if (start) begin
                        v1_r  <= v1;
                        v2_r  <= v2;
                        g_l_r <= g_l;
                        g_c_r <= g_c;
                        e_r   <= e_src;
                        busy  <= 1'b1;
                    end
                end
                MUL_L: p_l_r <= mul_p_s;
                MUL_C: p_c_r <= mul_p_s;
                UPD: begin
                    i_l_r <= sat_add(i_l_r, p_l_r);
                    i_c_r <= sat_sub(p_c_r, i_c_r);
                end
                DONE: begin
                    z0   <= sat_neg(i_l_r);
                    z1   <= sat_add(i_l_r, i_c_r);
                    z2   <= e_r;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_companion_history_update.sv
// Self-checking bench: integer-arithmetic timestep model compared every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_companion_history_update;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hist_clr = 1'b0;
    logic [15:0] v1 = 16'h0000, v2 = 16'h0000, g_l = 16'h0000, g_c = 16'h0000, e_src = 16'h0000;
    logic        busy, done;
    logic [15:0] z0, z1, z2;

    int tests = 0;
    int fails = 0;

    companion_history_update dut (
        .clk(clk), .rst(rst), .start(start), .hist_clr(hist_clr),
        .v1(v1), .v2(v2), .g_l(g_l), .g_c(g_c), .e_src(e_src),
        .busy(busy), .done(done), .z0(z0), .z1(z1), .z2(z2)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        else if (x < -32768) return -32768;
        else return x;
    endfunction

    function automatic int fmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat(int'(p >>> 8));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: a timestep is computed in full at acceptance and
    // becomes visible four cycles later.
    int m_il = 0, m_ic = 0, m_cnt = 0, m_z0 = 0, m_z1 = 0, m_z2 = 0;
    int p_il = 0, p_ic = 0, p_e = 0;
    bit m_done = 1'b0, m_ready = 1'b0;

    always @(posedge clk) begin
        int d;
        m_done = 1'b0;
        if (rst) begin
            m_il = 0; m_ic = 0; m_cnt = 0; m_z0 = 0; m_z1 = 0; m_z2 = 0;
            m_ready = 1'b1;
        end else if (m_cnt == 0) begin
            if (hist_clr) begin
                m_il = 0; m_ic = 0;
            end else if (start) begin
                d    = sat(sx(v1) - sx(v2));
                p_il = sat(m_il + fmul(d, sx(g_l)));
                p_ic = sat(fmul(sx(v2), sx(g_c)) - m_ic);
                p_e  = sx(e_src);
                m_cnt = 1;
            end
        end else if (m_cnt == 4) begin
            m_il = p_il; m_ic = p_ic;
            m_z0 = sat(-m_il); m_z1 = sat(m_il + m_ic); m_z2 = p_e;
            m_done = 1'b1;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("busy", int'(busy), int'(m_cnt != 0));
            chk("done", int'(done), int'(m_done));
            chk("z0", sx(z0), m_z0);
            chk("z1", sx(z1), m_z1);
            chk("z2", sx(z2), m_z2);
        end
    end

    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [15:0] gl,
                        input logic [15:0] gc, input logic [15:0] e, output int lat);
        @(negedge clk);
        v1 = a; v2 = b; g_l = gl; g_c = gc; e_src = e;
        start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic clear_hist();
        @(negedge clk); hist_clr = 1'b1;
        @(negedge clk); hist_clr = 1'b0;
    endtask

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 3))
            0: return ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
            1: return 16'($signed($urandom_range(0, 1023)) - 512);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int ndone;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_z0", int'(z0), 0);
        rst = 1'b0;

        step(16'h0200, 16'h0100, 16'h0040, 16'h0200, 16'h0700, lat);
        chk("s1_latency", lat, 5);
        chk("s1_z0", int'(z0), 32'h0000FFC0);
        chk("s1_z1", int'(z1), 32'h00000240);
        chk("s1_z2", int'(z2), 32'h00000700);

        step(16'h0200, 16'h0100, 16'h0040, 16'h0200, 16'h0700, lat);
        chk("s2_z0", int'(z0), 32'h0000FF80);
        chk("s2_z1", int'(z1), 32'h00000080);

        clear_hist();
        step(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0100, 16'h0000, lat);
        chk("sat_z0", int'(z0), 32'h00008001);
        chk("sat_z1", int'(z1), 32'h0000FFFF);

        clear_hist();
        step(16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 16'h0000, lat);
        chk("trunc_z0", int'(z0), 32'h00000001);
        chk("trunc_z1", int'(z1), 32'h0000FFFF);

        // Second start lands in MUL_C and must be ignored.
        ndone = 0;
        @(negedge clk);
        v1 = 16'h0200; v2 = 16'h0100; g_l = 16'h0040; g_c = 16'h0200; e_src = 16'h0700;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = (i == 2) ? 1'b1 : 1'b0;
            if (done) ndone++;
        end
        chk("busy_one_done", ndone, 1);

        // Clear and start together: no run, history zeroed.
        step(16'h0200, 16'h0100, 16'h0040, 16'h0200, 16'h0700, lat);
        @(negedge clk); hist_clr = 1'b1; start = 1'b1;
        @(negedge clk); hist_clr = 1'b0; start = 1'b0;
        chk("clrpri_busy", int'(busy), 0);
        step(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, lat);
        chk("clrpri_z0", int'(z0), 0);
        chk("clrpri_z1", int'(z1), 0);
        chk("clrpri_z2", int'(z2), 32'h00000100);

        // Reset while in MUL_C aborts without done.
        @(negedge clk);
        v1 = 16'h0200; v2 = 16'h0100; g_l = 16'h0040; g_c = 16'h0200; e_src = 16'h0700;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_z1", int'(z1), 0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rstmid_no_done", ndone, 0);
        step(16'h0200, 16'h0100, 16'h0040, 16'h0200, 16'h0700, lat);
        chk("rstmid_z0", int'(z0), 32'h0000FFC0);
        chk("rstmid_z1b", int'(z1), 32'h00000240);
        chk("rstmid_z2", int'(z2), 32'h00000700);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 63) == 0);
            start    = ($urandom_range(0, 2) == 0);
            hist_clr = ($urandom_range(0, 9) == 0);
            v1 = rand_val(); v2 = rand_val(); g_l = rand_val();
            g_c = rand_val(); e_src = rand_val();
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; hist_clr = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
